// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: synchronises the codec BCLK/ADCLRCK/ADCDAT into inclk and deserialises stereo pairs.
// Define I2S_PEAK_DETECT_EN to add per-channel absolute peak trackers (peak_clr, peak_l, peak_r).
module i2s_adc_receiver #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                inclk,
    input  logic                rst,
    input  logic                cfg_rdy,
    input  logic                aud_bclk,
    input  logic                aud_lrck,
    input  logic                aud_dat,
`ifdef I2S_PEAK_DETECT_EN
    input  logic                peak_clr,
`endif
    output logic [SAMPLE_W-1:0] sample_l,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    output logic                locked,
`ifdef I2S_PEAK_DETECT_EN
    output logic                frame_err,
    output logic [SAMPLE_W-2:0] peak_l,
    output logic [SAMPLE_W-2:0] peak_r
`else
    output logic                frame_err
`endif
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SKIP,
        SHIFT,
        DONE
    } state_t;

    // Each stage holds {bclk, lrck, dat}; the last stage feeds the edge detectors.
    logic [2:0] sync_reg [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge inclk) begin
                    if (rst) begin
                        sync_reg[0] <= '0;
                    end else begin
                        sync_reg[0] <= {aud_bclk, aud_lrck, aud_dat};
                    end
                end
            end else begin : g_next
                always_ff @(posedge inclk) begin
                    if (rst) begin
                        sync_reg[gi] <= '0;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic bclk_s;
    logic lrck_s;
    logic dat_s;

    assign bclk_s = sync_reg[SYNC_STAGES-1][2];
    assign lrck_s = sync_reg[SYNC_STAGES-1][1];
    assign dat_s  = sync_reg[SYNC_STAGES-1][0];

    logic bclk_prev_reg;
    logic lrck_prev_reg;
    logic bclk_rise_reg;
    logic lr_fall_reg;
    logic lr_rise_reg;
    logic lrck_lvl_reg;
    logic dat_reg;
    logic lr_edge;

    // Registered edge strobes; data and LR level are delayed by one cycle to stay aligned with them.
    always_ff @(posedge inclk) begin
        if (rst) begin
            bclk_prev_reg <= 1'b0;
            lrck_prev_reg <= 1'b0;
            bclk_rise_reg <= 1'b0;
            lr_fall_reg   <= 1'b0;
            lr_rise_reg   <= 1'b0;
            lrck_lvl_reg  <= 1'b0;
            dat_reg       <= 1'b0;
        end else begin
            bclk_prev_reg <= bclk_s;
            lrck_prev_reg <= lrck_s;
            bclk_rise_reg <= bclk_s & ~bclk_prev_reg;
            lr_fall_reg   <= ~lrck_s & lrck_prev_reg;
            lr_rise_reg   <= lrck_s & ~lrck_prev_reg;
            lrck_lvl_reg  <= lrck_s;
            dat_reg       <= dat_s;
        end
    end

    assign lr_edge = lr_fall_reg | lr_rise_reg;

    state_t                state_reg;
    logic                  chan_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [SAMPLE_W-1:0]   shift_reg;
    logic [SAMPLE_W-1:0]   hold_l_reg;
    logic [SAMPLE_W-1:0]   word_next;
    logic                  last_bit;

    assign word_next = {shift_reg[SAMPLE_W-2:0], dat_reg};
    assign last_bit  = (cnt_reg == CNT_W'(SAMPLE_W - 1));

    always_ff @(posedge inclk) begin
        if (rst) begin
            state_reg    <= IDLE;
            chan_reg     <= 1'b0;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            hold_l_reg   <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!cfg_rdy) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                locked    <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= ALIGN;
                    end
                    ALIGN: begin
                        if (lr_fall_reg) begin
                            chan_reg  <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= bclk_rise_reg ? SHIFT : SKIP;
                        end
                    end
                    SKIP, SHIFT: begin
                        if (lr_edge) begin
                            // Slot ended before a full word: drop it and resynchronise.
                            frame_err <= 1'b1;
                            locked    <= 1'b0;
                            cnt_reg   <= '0;
                            if (lr_fall_reg) begin
                                chan_reg  <= 1'b0;
                                state_reg <= bclk_rise_reg ? SHIFT : SKIP;
                            end else begin
                                state_reg <= ALIGN;
                            end
                        end else if (bclk_rise_reg) begin
                            if (state_reg == SKIP) begin
                                cnt_reg   <= '0;
                                state_reg <= SHIFT;
                            end else begin
                                shift_reg <= word_next;
                                cnt_reg   <= cnt_reg + 1'b1;
                                if (last_bit) begin
                                    state_reg <= DONE;
                                    if (!chan_reg) begin
                                        hold_l_reg <= word_next;
                                    end else begin
                                        sample_l     <= hold_l_reg;
                                        sample_r     <= word_next;
                                        sample_valid <= 1'b1;
                                        locked       <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (lr_edge) begin
                            cnt_reg <= '0;
                            if (lrck_lvl_reg == chan_reg) begin
                                frame_err <= 1'b1;
                                locked    <= 1'b0;
                                state_reg <= ALIGN;
                            end else begin
                                chan_reg  <= lrck_lvl_reg;
                                state_reg <= bclk_rise_reg ? SHIFT : SKIP;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef I2S_PEAK_DETECT_EN
    // Magnitude of a two's-complement sample; the most negative code saturates to the largest positive one.
    function automatic logic [SAMPLE_W-2:0] magnitude(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] neg;
        neg = ~s + 1'b1;
        if (!s[SAMPLE_W-1]) begin
            return s[SAMPLE_W-2:0];
        end else if (s[SAMPLE_W-2:0] == '0) begin
            return '1;
        end else begin
            return neg[SAMPLE_W-2:0];
        end
    endfunction

    logic [SAMPLE_W-2:0] mag_l;
    logic [SAMPLE_W-2:0] mag_r;

    assign mag_l = magnitude(sample_l);
    assign mag_r = magnitude(sample_r);

    always_ff @(posedge inclk) begin
        if (rst) begin
            peak_l <= '0;
            peak_r <= '0;
        end else if (sample_valid) begin
            peak_l <= (peak_clr || mag_l > peak_l) ? mag_l : peak_l;
            peak_r <= (peak_clr || mag_r > peak_r) ? mag_r : peak_r;
        end else if (peak_clr) begin
            peak_l <= '0;
            peak_r <= '0;
        end
    end
`endif

endmodule
